updown_counter_display: RTL
===========================

Name: updown_counter_display

Overview:
Parametrised, synchronously clocked up/down counter with an N-digit hex seven-segment readout. It replaces the two-digit countdown that used its button as a clock. A raw, asynchronous push-button level is synchronised and edge-detected into single-cycle step events. The block adds direction control, parallel load, wrap/saturate mode, a zero flag and a terminal-count pulse. It drives board 7-seg displays directly.

Parameters:
WIDTH, 6, counter width in bits (1..32)
DIGITS, 2, number of 7-seg digits driven; must satisfy 4*DIGITS >= WIDTH
START, 2**WIDTH-1, count value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  reset, asynchronous, active-high
step  input  1  raw button level, asynchronous to clk; each rising edge = one count step
dir  input  1  0 = count down, 1 = count up; sampled in the cycle the step pulse is applied
load  input  1  synchronous parallel load strobe, level-sampled each cycle
load_value  input  WIDTH  value written on load
wrap_en  input  1  1 = wrap at limits, 0 = saturate at limits
count  output  WIDTH  current count, registered
zero  output  1  high while count == 0, combinational from count
tc  output  1  one-cycle pulse when a step hits a limit, registered
seg  output  7*DIGITS  segments, active-low; seg[7i+6:7i] is digit i, bit order a(0)..g(6)

Behaviour:
- Reset (async assert, sync use): count = START, tc = 0, both synchroniser flops and edge-history flop = 1. A button held through reset release produces no step.
- Step path: step -> 2-flop synchroniser -> history flop; step_pulse = sync_q & ~hist_q. step_pulse is high for exactly one clk per rising edge of step.
- Latency: count changes on the 3rd rising clk edge after step rises, given setup is met.
- Priority each cycle: load > step_pulse > hold.
- load = 1: count <= load_value and tc <= 0. A coincident step_pulse is discarded, not deferred.
- step_pulse, dir = 0:
  - count > 0: count - 1.
  - count == 0 and wrap_en = 1: count <= 2**WIDTH-1, tc <= 1.
  - count == 0 and wrap_en = 0: hold at 0, tc <= 1.
- step_pulse, dir = 1:
  - count < 2**WIDTH-1: count + 1.
  - At max with wrap_en = 1: count <= 0, tc <= 1.
  - At max with wrap_en = 0: hold, tc <= 1.
- tc is 0 in every cycle not listed above. A saturated count pulses tc on every further step.
- Arithmetic is modulo 2**WIDTH with no carry out beyond WIDTH bits.
- Display: count is zero-extended to 4*DIGITS bits. Digit i shows nibble [4i+3:4i] as hex 0-F using standard glyphs (b and d lowercase, A C E F uppercase). Decoding is purely combinational from count, with no added latency.
- dir and wrap_en may change any cycle and take effect on the next applied step.
- Reset asserted mid-operation: immediate return to START, pending synchroniser state discarded.

Test Plan:
- Reset release with WIDTH=6, DIGITS=2, step low -> count=63, seg shows "3F" (digit1 = 0110000, digit0 = 0001110 active-low), zero=0, tc=0.
- From 63, 63 step rising edges, dir=0 -> count=0, zero=1, tc never high. 64th edge with wrap_en=1 -> count=63, tc high exactly 1 cycle.
- count=0, wrap_en=0, dir=0, 3 steps -> count stays 0, three separate 1-cycle tc pulses. Switch dir=1 and step once -> count=1, tc=0.
- load=1 with load_value=42 in the same cycle as step_pulse -> count=42 next cycle, no decrement then or later, seg "2A".
- step held high for 100 cycles -> exactly one decrement, 3 clk edges after the rise. step held high across a reset pulse -> no decrement after release.
- WIDTH=10, DIGITS=3, dir=1, load 1023, one step with wrap_en=1 -> count=0, tc pulse, seg "000". Reset asserted mid-count -> count=1023 asynchronously, without waiting for clk.

Source files
------------

// File: rtl/updown_counter_display.sv
// updown_counter_display: button-stepped up/down counter with load, wrap/saturate, flags and hex 7-seg readout
module updown_counter_display #(
  parameter int WIDTH = 6,
  parameter int DIGITS = 2,
  parameter logic [WIDTH-1:0] START = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step,
  input  logic                  dir,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  wrap_en,
  output logic [WIDTH-1:0]      count,
  output logic                  zero,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   seg
);
  // Active-high glyphs indexed by nibble, bit 0 = segment a; inverted at the pins.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic                sync1_q, sync2_q, hist_q;
  logic                step_pulse, at_lim;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                tc_q, tc_d;
  logic [4*DIGITS-1:0] hex;
  // Synchronise the raw button; flops reset high so a button held through reset gives no step.
  always_ff @(posedge clk or posedge reset)
    if (reset) {sync1_q, sync2_q, hist_q} <= 3'b111;
    else {sync1_q, sync2_q, hist_q} <= {step, sync1_q, sync2_q};
  assign step_pulse = sync2_q & ~hist_q;
  // Next count: load wins and swallows a coincident step; wrapping falls out of modulo arithmetic.
  always_comb begin
    at_lim  = dir ? &count_q : ~|count_q;
    count_d = load ? load_value :
              (!step_pulse || (at_lim && !wrap_en)) ? count_q :
              dir ? count_q + 1'b1 : count_q - 1'b1;
    tc_d    = !load && step_pulse && at_lim;
  end
  // Count and terminal-count registers.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count_q <= START;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  assign count = count_q;
  assign tc    = tc_q;
  assign zero  = ~|count_q;
  assign hex   = (4*DIGITS)'(count_q);
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign seg[7*i +: 7] = ~GLYPH[hex[4*i +: 4]];
  end
endmodule
